// File: rtl/ro_bus_rx.sv
// ----------------------------------------------------------------------------
// ro_bus_rx
//
// Receive side of a slot-scheduled, shared tri-stated readout bus. A binary
// schedule counter advances while `en` is high. Its gray-coded value is
// registered and broadcast to the transmit-side readout blocks; each advance
// selects the channel slot given by the trailing-zero count of the new counter
// value. One cycle after an advance (bus turnaround), the two bus lines are
// sampled. The result {channel, eve, pol_eve} is queued in a small FIFO with a
// ready/valid output.
//
// Parameters
//   NCH    number of channel slots (= schedule counter / gray width)
//   DEPTH  record FIFO depth, power of two, >= 2
//
// Ports
//   clk_master   in   single clock, rising edge
//   reset        in   asynchronous, active-high reset
//   en           in   schedule advance enable
//   bus_eve      in   shared readout line "eve"
//   bus_pol_eve  in   shared readout line "pol_eve"
//   out_ready    in   consumer ready
//   out_valid    out  record available at FIFO head
//   out_chan     out  channel index of head record (0 when empty)
//   out_eve      out  sampled eve bit of head record (0 when empty)
//   out_pol_eve  out  sampled pol_eve bit of head record (0 when empty)
//   gray         out  registered gray code of the schedule counter
//   overflow     out  sticky: a record was dropped because the FIFO was full
//   level        out  FIFO occupancy
//
// Configuration macro
//   RO_RX_ZERO_SUPPRESS_EN  when defined, slots sampled as eve=0/pol_eve=0
//                           are not queued and cannot raise overflow.
// ----------------------------------------------------------------------------
module ro_bus_rx #(
    parameter int NCH   = 19,
    parameter int DEPTH = 8
) (
    input  logic                   clk_master,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   bus_eve,
    input  logic                   bus_pol_eve,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [4:0]             out_chan,
    output logic                   out_eve,
    output logic                   out_pol_eve,
    output logic [NCH-1:0]         gray,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef struct packed {
        logic [4:0] chan;
        logic       eve;
        logic       pol;
    } rec_t;

    // Slot selected by a counter value: index of its lowest set bit. The
    // all-zero value (wrap) belongs to the top slot, so every slot k recurs
    // every 2^(k+1) advances.
    function automatic logic [4:0] slot_of(input logic [NCH-1:0] c);
        logic [4:0] r;
        r = 5'(NCH - 1);
        for (int i = NCH - 1; i >= 0; i--) begin
            if (c[i]) r = 5'(i);
        end
        return r;
    endfunction

    function automatic logic [NCH-1:0] to_gray(input logic [NCH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // ---------------- schedule stage: counter, gray, pending slot ----------
    logic [NCH-1:0] cnt_q,       cnt_d;
    logic [NCH-1:0] gray_q,      gray_d;
    logic           pend_q,      pend_d;
    logic [4:0]     pend_chan_q, pend_chan_d;

    always_comb begin
        cnt_d       = cnt_q;
        gray_d      = gray_q;
        pend_chan_d = pend_chan_q;
        // A pending slot is consumed by the sampler on every edge; it only
        // survives if a fresh advance re-arms it on that same edge.
        pend_d      = 1'b0;
        if (en) begin
            cnt_d       = cnt_q + NCH'(1);
            gray_d      = to_gray(cnt_d);
            pend_d      = 1'b1;
            pend_chan_d = slot_of(cnt_d);
        end
    end

    always_ff @(posedge clk_master or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            gray_q      <= '0;
            pend_q      <= 1'b0;
            pend_chan_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            gray_q      <= gray_d;
            pend_q      <= pend_d;
            pend_chan_q <= pend_chan_d;
        end
    end

    assign gray = gray_q;

    // ---------------- sample stage: bus capture one cycle after advance ----
    rec_t sample_rec;
    logic push_req;

    always_comb begin
        sample_rec.chan = pend_chan_q;
        sample_rec.eve  = bus_eve;
        sample_rec.pol  = bus_pol_eve;
`ifdef RO_RX_ZERO_SUPPRESS_EN
        push_req = pend_q && (bus_eve || bus_pol_eve);
`else
        push_req = pend_q;
`endif
    end

    // ---------------- record FIFO ------------------------------------------
    rec_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [LW-1:0] level_q,    level_d;
    logic          overflow_q, overflow_d;
    logic          pop;
    logic          full;
    logic          push;

    always_comb begin
        pop        = (level_q != '0) && out_ready;
        full       = (level_q == FULL_LVL);
        // A pop on the same edge frees the slot, so a full FIFO still
        // accepts the record in that case.
        push       = push_req && (!full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
        if (push_req && !push) overflow_d = 1'b1;
    end

    always_ff @(posedge clk_master or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries data only; emptiness is tracked by level, so no reset.
    always_ff @(posedge clk_master) begin
        if (push) mem_q[wr_ptr_q] <= sample_rec;
    end

    rec_t head;
    assign head        = mem_q[rd_ptr_q];
    assign out_valid   = (level_q != '0);
    assign out_chan    = out_valid ? head.chan : 5'd0;
    assign out_eve     = out_valid ? head.eve  : 1'b0;
    assign out_pol_eve = out_valid ? head.pol  : 1'b0;
    assign overflow    = overflow_q;
    assign level       = level_q;

endmodule

// File: tb/tb_ro_bus_rx.sv
module tb_ro_bus_rx;

    localparam int NCH   = 19;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             en;
    logic             bus_eve;
    logic             bus_pol_eve;
    logic             out_ready;
    logic             out_valid;
    logic [4:0]       out_chan;
    logic             out_eve;
    logic             out_pol_eve;
    logic [NCH-1:0]   gray;
    logic             overflow;
    logic [LW-1:0]    level;

    logic             v4;
    logic [4:0]       chan4;
    logic             eve4;
    logic             pol4;
    logic [3:0]       gray4;
    logic             ovf4;
    logic [LW-1:0]    level4;

    ro_bus_rx #(.NCH(NCH), .DEPTH(DEPTH)) dut (
        .clk_master (clk),
        .reset      (reset),
        .en         (en),
        .bus_eve    (bus_eve),
        .bus_pol_eve(bus_pol_eve),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_chan   (out_chan),
        .out_eve    (out_eve),
        .out_pol_eve(out_pol_eve),
        .gray       (gray),
        .overflow   (overflow),
        .level      (level)
    );

    ro_bus_rx #(.NCH(4), .DEPTH(DEPTH)) dut4 (
        .clk_master (clk),
        .reset      (reset),
        .en         (en),
        .bus_eve    (bus_eve),
        .bus_pol_eve(bus_pol_eve),
        .out_ready  (1'b1),
        .out_valid  (v4),
        .out_chan   (chan4),
        .out_eve    (eve4),
        .out_pol_eve(pol4),
        .gray       (gray4),
        .overflow   (ovf4),
        .level      (level4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    int n_rec = 0;

    int G [8]  = '{1, 3, 2, 6, 7, 5, 4, 12};
    int C [10] = '{0, 1, 0, 2, 0, 1, 0, 3, 0, 1};

    logic [6:0]     sb [$];
    logic [NCH-1:0] m_cnt;
    logic           m_pend;
    logic [4:0]     m_chan;
    logic           m_ovf;

    function automatic logic [4:0] exp_chan(input logic [NCH-1:0] c);
        if (c == '0) return 5'(NCH - 1);
        for (int k = 0; k < NCH; k++) begin
            if (c[k]) return 5'(k);
        end
        return 5'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_cnt  = '0;
        m_pend = 1'b0;
        m_chan = '0;
        m_ovf  = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_head"}, 32'({out_chan, out_eve, out_pol_eve}), 0);
        chk({tag, "_gray"}, 32'(gray), 0);
        chk({tag, "_ovf"}, 32'(overflow), 0);
        chk({tag, "_level"}, 32'(level), 0);
        chk({tag, "_n4_gray"}, 32'(gray4), 0);
        chk({tag, "_n4_level"}, 32'(level4), 0);
    endtask

    // One clock: pre-edge head/valid checks against the scoreboard, model
    // update for the edge, then post-edge state checks.
    task automatic step();
        logic [6:0] rec;
        logic       ev;
        logic       keep;
        ev = (sb.size() != 0);
        chk("out_valid", 32'(out_valid), 32'(ev));
        if (out_valid && out_ready) n_pop++;
        if (ev && out_ready) begin
            rec = sb.pop_front();
            chk("pop_head", 32'({out_chan, out_eve, out_pol_eve}), 32'(rec));
        end else if (ev) begin
            chk("hold_head", 32'({out_chan, out_eve, out_pol_eve}), 32'(sb[0]));
        end else begin
            chk("empty_head", 32'({out_chan, out_eve, out_pol_eve}), 0);
        end
        keep = 1'b1;
`ifdef RO_RX_ZERO_SUPPRESS_EN
        keep = bus_eve | bus_pol_eve;
`endif
        if (m_pend && keep) begin
            if (sb.size() == DEPTH) m_ovf = 1'b1;
            else sb.push_back({m_chan, bus_eve, bus_pol_eve});
        end
        if (en) begin
            m_cnt  = m_cnt + NCH'(1);
            m_pend = 1'b1;
            m_chan = exp_chan(m_cnt);
        end else begin
            m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        chk("gray", 32'(gray), 32'(m_cnt ^ (m_cnt >> 1)));
        chk("level", 32'(level), 32'(sb.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    task automatic do_reset();
        en = 1'b0;
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk_all_zero("rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        en = 1'b0;
        bus_eve = 1'b0;
        bus_pol_eve = 1'b0;
        out_ready = 1'b0;
        model_clear();
        do_reset();

        // Bus tied high, free-running schedule; NCH=4 instance wraps at 16.
        bus_eve = 1'b1;
        bus_pol_eve = 1'b1;
        out_ready = 1'b1;
        en = 1'b1;
        for (int e = 1; e <= 18; e++) begin
            step();
            if (e == 1) chk("first_valid_e1", 32'(out_valid), 0);
            if (e == 2) chk("first_valid_e2", 32'(out_valid), 1);
            if (e <= 8) chk("gray_seq", 32'(gray), 32'(G[e-1]));
            if (e >= 2 && e <= 11) chk("chan_seq", 32'(out_chan), 32'(C[e-2]));
            if (e == 15) chk("n4_gray_15", 32'(gray4), 8);
            if (e == 16) chk("n4_gray_wrap", 32'(gray4), 0);
            if (e == 17) begin
                chk("n4_wrap_chan", 32'(chan4), 3);
                chk("n4_valid", 32'(v4), 1);
                chk("n4_level", 32'(level4), 1);
                chk("n4_bits", 32'({eve4, pol4}), 3);
                chk("n4_ovf", 32'(ovf4), 0);
            end
            if (e == 18) chk("n4_after_wrap_chan", 32'(chan4), 0);
        end

        // Fill with consumer stalled, overflow on the 9th record, then drain.
        do_reset();
        out_ready = 1'b0;
        bus_eve = 1'b1;
        en = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            bus_pol_eve = e[0];
            step();
            if (e == 9) begin
                chk("fill_level_9", 32'(level), 8);
                chk("fill_ovf_9", 32'(overflow), 0);
            end
            if (e == 10) begin
                chk("drop_level_10", 32'(level), 8);
                chk("drop_ovf_10", 32'(overflow), 1);
            end
        end
        en = 1'b0;
        step();
        out_ready = 1'b1;
        n_pop = 0;
        repeat (10) step();
        chk("drain_pops", 32'(n_pop), 8);
        chk("drain_level", 32'(level), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // Full FIFO with simultaneous push and pop keeps level at DEPTH.
        out_ready = 1'b0;
        en = 1'b1;
        repeat (9) step();
        out_ready = 1'b1;
        repeat (3) begin
            step();
            chk("full_pushpop_level", 32'(level), 8);
        end
        en = 1'b0;
        repeat (10) step();
        chk("full_drain_level", 32'(level), 0);

        // Enable dropped after an advance: schedule frozen, one record out.
        do_reset();
        bus_eve = 1'b1;
        bus_pol_eve = 1'b1;
        out_ready = 1'b1;
        en = 1'b1;
        repeat (3) step();
        en = 1'b0;
        n_rec = 0;
        repeat (5) begin
            step();
            chk("hold_gray", 32'(gray), 2);
            if (out_valid) n_rec++;
        end
        chk("hold_records", 32'(n_rec), 1);
        en = 1'b1;
        step();
        chk("resume_gray", 32'(gray), 6);
        step();
        chk("resume_chan", 32'(out_chan), 2);

        // Asynchronous reset with queued records and a pending sample.
        do_reset();
        out_ready = 1'b0;
        en = 1'b1;
        repeat (6) step();
        chk("pre_rst_level", 32'(level), 5);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        chk("post_rst_valid", 32'(out_valid), 1);
        chk("post_rst_chan", 32'(out_chan), 0);

        // Only the slot for channel 2 sees a nonzero bus.
        do_reset();
        out_ready = 1'b0;
        bus_pol_eve = 1'b0;
        en = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            bus_eve = (e == 5);
            step();
        end
`ifdef RO_RX_ZERO_SUPPRESS_EN
        chk("zs_level", 32'(level), 1);
        chk("zs_head", 32'({out_chan, out_eve, out_pol_eve}), 32'h0A);
`else
        chk("nozs_level", 32'(level), 5);
        chk("nozs_head", 32'({out_chan, out_eve, out_pol_eve}), 0);
`endif
        chk("zs_ovf", 32'(overflow), 0);

        // Mixed random traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 60; i++) begin
            en          = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            bus_eve     = 1'($urandom_range(0, 1));
            bus_pol_eve = 1'($urandom_range(0, 1));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ro_bus_rx.md
RO_BUS_RX -- requirements
Module: ro_bus_rx

Interface
REQ-001 SHALL have parameter NCH, default 19, meaning number of channel slots, equal to the gray counter width.
REQ-002 SHALL have parameter DEPTH, default 8, meaning record FIFO depth; it SHALL be a power of 2, minimum 2.
REQ-003 SHALL have port clk_master, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port en, input, 1 bit: slot-schedule advance enable.
REQ-006 SHALL have ports bus_eve and bus_pol_eve, input, 1 bit each: the shared tri-stated readout lines (eve and pol_eve).
REQ-007 SHALL have port out_ready, input, 1 bit: consumer ready.
REQ-008 SHALL have port out_valid, output, 1 bit: a record is available at the FIFO head.
REQ-009 SHALL have port out_chan, output, 5 bits: channel index of the head record.
REQ-010 SHALL have ports out_eve and out_pol_eve, output, 1 bit each: sampled bus bits of the head record.
REQ-011 SHALL have port gray, output, NCH bits: the schedule gray code, driven to the transmit-side readout blocks.
REQ-012 SHALL have port overflow, output, 1 bit: sticky dropped-record flag.
REQ-013 SHALL have port level, output, clog2(DEPTH)+1 bits: FIFO occupancy.

Function
REQ-014 SHALL hold an NCH-bit binary counter cnt that increments by 1 per edge while en=1 and wraps from 2^NCH-1 to 0.
REQ-015 SHALL drive gray as a register equal to cnt^(cnt>>1), updated on the same edge as cnt, with no combinational path to the output.
REQ-016 On each advance, SHALL set pend=1 and pend_chan to the trailing-zero count of the new cnt; when the new cnt is 0 (wrap), pend_chan SHALL be NCH-1.
REQ-017 Consequently, channel k SHALL be scheduled once every 2^(k+1) advances.
REQ-018 On the edge after pend is set, SHALL sample bus_eve and bus_pol_eve and form a record {pend_chan, eve, pol_eve}, independent of en; this gives a one-cycle bus turnaround.
REQ-019 pend SHALL clear after sampling unless a new advance occurs on the same edge.
REQ-020 The formed record SHALL be pushed into the FIFO, subject to REQ-033.
REQ-021 FIFO handshake: a pop SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-022 out_valid SHALL equal (level!=0); out_chan, out_eve and out_pol_eve SHALL reflect the head record, and SHALL be 0 when the FIFO is empty.
REQ-023 Push when full without a simultaneous pop: the record SHALL be dropped, overflow SHALL be set to 1, and level SHALL stay at DEPTH.
REQ-024 Push when full with a simultaneous pop: both SHALL be accepted, and level SHALL stay at DEPTH.
REQ-025 Push and pop when empty: the record SHALL enter the FIFO, out_valid SHALL rise on the following edge, and the pop SHALL be ignored.
REQ-026 overflow SHALL clear only on reset.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 Latency: bus sample to out_valid SHALL be 1 cycle when the FIFO was empty.

Reset
REQ-029 reset=1 SHALL asynchronously force cnt=0, gray=0, pend=0, pend_chan=0 and empty FIFO pointers.
REQ-030 reset=1 SHALL asynchronously force out_valid=0, out_chan=0, out_eve=0, out_pol_eve=0, overflow=0 and level=0.
REQ-031 Reset asserted mid-operation SHALL discard the pending sample and all queued records.
REQ-032 The first advance after reset deassertion SHALL produce cnt=1 and pend_chan=0.

Configuration
REQ-033 Macro RO_RX_ZERO_SUPPRESS_EN: when defined, records with eve=0 and pol_eve=0 SHALL NOT be pushed and SHALL NOT set overflow.
REQ-034 When RO_RX_ZERO_SUPPRESS_EN is undefined, every sampled slot SHALL be pushed.

Verification
REQ-035 Macro undefined, bus tied 1/1, out_ready=1, en=1 after reset -> first out_valid after edge 2; out_chan sequence 0,1,0,2,0,1,0,3,0,1; gray sequence 1,3,2,6,7,5,4,12.
REQ-036 DEPTH=8, out_ready=0, macro undefined -> level reaches 8 after 9 edges; the 9th record is dropped and overflow=1; releasing out_ready pops exactly 8 records in order.
REQ-037 NCH=4: 16 advances from reset -> cnt 15->0, gray 8->0, pend_chan=3 on wrap; 17th advance -> pend_chan=0.
REQ-038 Macro defined, bus_eve=1 only in the cycle sampling channel 2 -> exactly one record {2,1,0}; overflow stays 0.
REQ-039 en dropped for 5 cycles right after an advance -> gray frozen; exactly one record emitted for the pending slot; resume continues from the next cnt.
REQ-040 reset pulsed with level=5 and pend=1 -> outputs 0 within the same cycle (asynchronous); the first record after release is chan 0.
